text_buffer: RTL
================

// Module: text_buffer
// PURPOSE
//  Text-mode character store feeding console: holds a COLUMNS x ROWS grid of {attribute,character}
//  cells, accepts a character stream with cursor/newline/scroll handling, and returns the cell
//  under the current pixel (cx,cy). Sits between a character source (UART/counter) and console;
//  replaces ad-hoc per-row character generation in top levels.
// PARAMETERS
//  COLUMNS     80      cells per row (cell width 8 px, cx>>3)
//  ROWS        30      cells per column (cell height 16 px, cy>>4)
//  BLANK_CHAR  8'h20   character used for cleared cells / out-of-range reads
//  BLANK_ATTR  8'h0F   attribute used for cleared cells / out-of-range reads
// PORTS
//  clk_pixel  in   1   sole clock (pixel clock)
//  reset      in   1   synchronous, active-high
//  wr_valid   in   1   stream byte valid
//  wr_ready   out  1   block can accept byte this cycle
//  wr_char    in   8   character / control code
//  wr_attr    in   8   attribute for printable wr_char
//  cx, cy     in   10  current pixel coordinates from hdmi
//  character  out  8   cell character, 2-cycle latency vs cx/cy
//  attribute  out  8   cell attribute, 2-cycle latency vs cx/cy
//  cursor_x   out  7   current column;  cursor_y  out 5  current logical row
// BEHAVIOUR
//  - Storage: COLUMNS*ROWS x 16 bit, one write port, one registered read port; read-during-write
//    to same address returns OLD data. Physical row = (top_row + logical_row) mod ROWS via
//    compare-subtract (no divider); address = phys_row*COLUMNS + col.
//  - Reset: state CLEAR_ALL, cursor (0,0), top_row 0, wr_ready 0, character/attribute = BLANK.
//    Reset mid-operation (any state) aborts and restarts CLEAR_ALL next cycle.
//  - CLEAR_ALL: writes BLANK to every address, one per cycle (2400 cycles default) -> IDLE.
//  - IDLE: wr_ready=1. Byte accepted on wr_valid&&wr_ready:
//     8'h0A newline: col<=0; if row<ROWS-1 row++ else SCROLL.
//     8'h0D: col<=0.   8'h08: col<=col-1 if col>0 (no erase).
//     other: write {wr_attr,wr_char} at (row,col); col++; if col reaches COLUMNS treat as newline
//     (same cycle; may SCROLL).
//  - SCROLL: top_row <= (top_row+1) mod ROWS, row stays ROWS-1, enter CLEAR_LINE on physical row
//    = old top_row (new bottom line).
//  - CLEAR_LINE: wr_ready=0, writes BLANK to COLUMNS cells, one per cycle, then IDLE.
//  - wr_ready is a registered function of state; never high in CLEAR_ALL/CLEAR_LINE.
//  - Read: stage 1 registers address + in_range (cx>>3 < COLUMNS && cy>>4 < ROWS) using current
//    top_row; stage 2 registers RAM data. Out of range -> BLANK_CHAR/BLANK_ATTR. Reads continue
//    during clears (cells appear blank progressively). Top level delays cx/cy by 2 into console.
// STRUCTURE
//  - text_buffer_pkg: state enum {CLEAR_ALL,IDLE,CLEAR_LINE}, control-code constants (0A,0D,08),
//    address/col/row widths from $clog2, BLANK defaults.
//  - Sub-module text_ram: inferred simple dual-port RAM, registered read, old-data RDW.
// TESTING
//  1. Reset 1 cycle -> wr_ready 0 for 2400 cycles then 1; any in-range cx,cy reads 8'h20/8'h0F.
//  2. Write 8'h41 attr 8'h1E; cx=3,cy=5 -> character 8'h41, attribute 8'h1E two cycles later;
//     cursor_x=1.
//  3. Write 81 chars 8'h30..: 80th lands (79,0), cursor -> (0,1), 81st read at cx=0,cy=16.
//  4. 'X' at (0,0) then 30 x 8'h0A: 30th scrolls -> wr_ready 0 for 80 cycles, top_row=1, screen
//     row 0 no longer shows 'X', cx=0,cy=464 reads 8'h20.
//  5. cx=640 or cy=480 (any stored data) -> 8'h20/8'h0F.
//  6. Assert reset during CLEAR_LINE -> cursor (0,0), top_row 0, full 2400-cycle clear repeated.

Source files
------------

// File: rtl/text_buffer_pkg.sv
// Shared types, control codes and default geometry for the text buffer.
package text_buffer_pkg;

    // Default grid geometry. The address and cursor widths are derived from these
    // values, so any override of the grid size must fit inside them.
    localparam int COLUMNS_DEF = 80;
    localparam int ROWS_DEF    = 30;
    localparam int CELLS_DEF   = COLUMNS_DEF * ROWS_DEF;

    localparam int ADDR_W = $clog2(CELLS_DEF);
    localparam int COL_W  = $clog2(COLUMNS_DEF);
    localparam int ROW_W  = $clog2(ROWS_DEF);
    localparam int CELL_W = 16;

    // Cell contents used for cleared cells and for reads outside the grid.
    localparam logic [7:0] BLANK_CHAR_DEF = 8'h20;
    localparam logic [7:0] BLANK_ATTR_DEF = 8'h0F;

    // Stream control codes.
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_CR = 8'h0D;
    localparam logic [7:0] CODE_BS = 8'h08;

    typedef enum logic [1:0] {
        ST_CLEAR_ALL  = 2'd0,
        ST_IDLE       = 2'd1,
        ST_CLEAR_LINE = 2'd2
    } state_t;

    // Pack attribute and character into one stored cell word.
    function automatic logic [CELL_W-1:0] make_cell(input logic [7:0] attr, input logic [7:0] ch);
        return {attr, ch};
    endfunction

endpackage

// File: rtl/text_buffer_ram.sv
// Simple dual-port cell store: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old contents.
module text_buffer_ram
    import text_buffer_pkg::*;
#(
    parameter int DEPTH = CELLS_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [CELL_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [CELL_W-1:0] rdata
);

    logic [CELL_W-1:0] mem_r [DEPTH];

    // Write port and registered read; non-blocking order gives old-data read-during-write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/text_buffer.sv
// Text-mode character store: cursor/newline/scroll handling on the write side,
// two-stage pixel-to-cell lookup on the read side.
module text_buffer
    import text_buffer_pkg::*;
#(
    parameter int         COLUMNS    = COLUMNS_DEF,
    parameter int         ROWS       = ROWS_DEF,
    parameter logic [7:0] BLANK_CHAR = BLANK_CHAR_DEF,
    parameter logic [7:0] BLANK_ATTR = BLANK_ATTR_DEF
) (
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [7:0]       wr_char,
    input  logic [7:0]       wr_attr,
    input  logic [9:0]       cx,
    input  logic [9:0]       cy,
    output logic [7:0]       character,
    output logic [7:0]       attribute,
    output logic [COL_W-1:0] cursor_x,
    output logic [ROW_W-1:0] cursor_y
);

    localparam int CELLS = COLUMNS * ROWS;

    // Logical row -> physical row, wrapping with one compare-subtract.
    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] top,
                                                  input logic [ROW_W-1:0] lrow);
        logic [ROW_W:0] sum;
        sum = {1'b0, top} + {1'b0, lrow};
        if (sum >= (ROW_W+1)'(ROWS)) begin
            sum = sum - (ROW_W+1)'(ROWS);
        end else begin
            sum = sum;
        end
        return sum[ROW_W-1:0];
    endfunction

    // Physical row and column -> linear cell address.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                    input logic [COL_W-1:0] col);
        return ADDR_W'(prow) * ADDR_W'(COLUMNS) + ADDR_W'(col);
    endfunction

    state_t            state_r, next_state_s;
    logic              wr_ready_r;
    logic [COL_W-1:0]  col_r, col_next_s;
    logic [ROW_W-1:0]  row_r, row_next_s;
    logic [ROW_W-1:0]  top_r, top_inc_s;
    logic [ROW_W-1:0]  clr_row_r;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic              accept_s, scroll_s, printable_s;

    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [CELL_W-1:0] wdata_s;

    logic              in_range_s, in_range_r, in_range_r2;
    logic [ADDR_W-1:0] raddr_s, raddr_r;
    logic [CELL_W-1:0] rdata_s;
    logic              unused_s;

    assign accept_s    = wr_valid && wr_ready_r && (state_r == ST_IDLE);
    assign printable_s = (wr_char != CODE_LF) && (wr_char != CODE_CR) && (wr_char != CODE_BS);
    assign top_inc_s   = (top_r == ROW_W'(ROWS - 1)) ? '0 : top_r + ROW_W'(1);

    // Cursor movement for an accepted byte; flags a scroll when a newline leaves the last row.
    always_comb begin
        col_next_s = col_r;
        row_next_s = row_r;
        scroll_s   = 1'b0;
        if (accept_s) begin
            case (wr_char)
                CODE_LF: begin
                    col_next_s = '0;
                    if (row_r < ROW_W'(ROWS - 1)) begin
                        row_next_s = row_r + ROW_W'(1);
                    end else begin
                        scroll_s = 1'b1;
                    end
                end
                CODE_CR: begin
                    col_next_s = '0;
                end
                CODE_BS: begin
                    if (col_r != '0) begin
                        col_next_s = col_r - COL_W'(1);
                    end else begin
                        col_next_s = col_r;
                    end
                end
                default: begin
                    if (col_r == COL_W'(COLUMNS - 1)) begin
                        col_next_s = '0;
                        if (row_r < ROW_W'(ROWS - 1)) begin
                            row_next_s = row_r + ROW_W'(1);
                        end else begin
                            scroll_s = 1'b1;
                        end
                    end else begin
                        col_next_s = col_r + COL_W'(1);
                    end
                end
            endcase
        end else begin
            col_next_s = col_r;
        end
    end

    // Next state and write-port control; clears write blanks, IDLE writes printable bytes.
    always_comb begin
        next_state_s = state_r;
        we_s         = 1'b0;
        waddr_s      = '0;
        wdata_s      = make_cell(BLANK_ATTR, BLANK_CHAR);
        case (state_r)
            ST_CLEAR_ALL: begin
                we_s    = 1'b1;
                waddr_s = clr_cnt_r;
                if (clr_cnt_r == ADDR_W'(CELLS - 1)) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_CLEAR_ALL;
                end
            end
            ST_IDLE: begin
                if (accept_s && printable_s) begin
                    we_s    = 1'b1;
                    waddr_s = cell_addr(phys_row(top_r, row_r), col_r);
                    wdata_s = make_cell(wr_attr, wr_char);
                end else begin
                    we_s = 1'b0;
                end
                if (scroll_s) begin
                    next_state_s = ST_CLEAR_LINE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CLEAR_LINE: begin
                we_s    = 1'b1;
                waddr_s = cell_addr(clr_row_r, clr_cnt_r[COL_W-1:0]);
                if (clr_cnt_r == ADDR_W'(COLUMNS - 1)) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_CLEAR_LINE;
                end
            end
            default: begin
                next_state_s = ST_CLEAR_ALL;
            end
        endcase
    end

    // Control registers: state, ready, cursor, scroll origin and clear counter.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_r    <= ST_CLEAR_ALL;
            wr_ready_r <= 1'b0;
            col_r      <= '0;
            row_r      <= '0;
            top_r      <= '0;
            clr_row_r  <= '0;
            clr_cnt_r  <= '0;
        end else begin
            state_r    <= next_state_s;
            wr_ready_r <= (next_state_s == ST_IDLE);
            col_r      <= col_next_s;
            row_r      <= row_next_s;
            if (scroll_s) begin
                top_r     <= top_inc_s;
                clr_row_r <= top_r;
            end else begin
                top_r     <= top_r;
                clr_row_r <= clr_row_r;
            end
            if ((next_state_s == state_r) && (state_r != ST_IDLE)) begin
                clr_cnt_r <= clr_cnt_r + ADDR_W'(1);
            end else begin
                clr_cnt_r <= '0;
            end
        end
    end

    // Pixel-to-cell mapping; out-of-grid pixels read address 0 and are masked later.
    always_comb begin
        in_range_s = (cx[9:3] < 7'(COLUMNS)) && (cy[9:4] < 6'(ROWS));
        if (in_range_s) begin
            raddr_s = cell_addr(phys_row(top_r, cy[4+ROW_W-1:4]), cx[3+COL_W-1:3]);
        end else begin
            raddr_s = '0;
        end
    end

    assign unused_s = ^{cx[2:0], cy[3:0]};

    // Read pipeline: stage 1 holds the address, the range flag follows the RAM data.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            raddr_r     <= '0;
            in_range_r  <= 1'b0;
            in_range_r2 <= 1'b0;
        end else begin
            raddr_r     <= raddr_s;
            in_range_r  <= in_range_s;
            in_range_r2 <= in_range_r;
        end
    end

    text_buffer_ram #(
        .DEPTH (CELLS)
    ) u_ram (
        .clk   (clk_pixel),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .raddr (raddr_r),
        .rdata (rdata_s)
    );

    assign character = in_range_r2 ? rdata_s[7:0]  : BLANK_CHAR;
    assign attribute = in_range_r2 ? rdata_s[15:8] : BLANK_ATTR;
    assign wr_ready  = wr_ready_r;
    assign cursor_x  = col_r;
    assign cursor_y  = row_r;

endmodule
